// File: rtl/grayscale_frame_streamer.sv
// Grayscale frame streamer: reads one frame of 8-bit pixels from a synchronous
// frame RAM in raster order and presents each pixel with a one-cycle done_o
// strobe. The pixel rate is set by a programmable inter-pixel gap, and hold_i
// pauses read issue without disturbing reads already in flight.
module grayscale_frame_streamer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int GAP        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [7:0]            mem_data_i,
    output logic [7:0]            grayscale_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(GAP);
    localparam logic [GAP_W-1:0]      GAP_ZERO  = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]      GAP_ONE   = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pix_idx_q;
    logic [ADDR_WIDTH-1:0]   pix_idx_d;
    logic [GAP_W-1:0]        gap_q;
    logic [GAP_W-1:0]        gap_d;

    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_rd_q;
    logic                    vld_q;
    logic [7:0]              gray_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    frame_done_q;

    logic                    launch_s;
    logic                    issue_s;
    logic [ADDR_WIDTH-1:0]   issue_idx_s;
    logic                    last_issue_s;
    logic                    drain_done_s;

    // Read-issue decision: a start in IDLE may issue pixel 0 on the same edge,
    // otherwise RUN issues whenever the gap has elapsed and hold is low.
    always_comb begin
        launch_s     = (state_q == ST_IDLE) && start_i;
        issue_idx_s  = pix_idx_q;
        if (launch_s) begin
            issue_idx_s = ADDR_ZERO;
        end else begin
            issue_idx_s = pix_idx_q;
        end
        issue_s      = !hold_i && (launch_s || ((state_q == ST_RUN) && (gap_q == GAP_ZERO)));
        last_issue_s = issue_s && (issue_idx_s == LAST_IDX);
        // The last strobe is on done_o with nothing left in the read pipe.
        drain_done_s = done_q && !vld_q && !mem_rd_q;
    end

    // Next values of the pixel index and gap counters.
    always_comb begin
        pix_idx_d = pix_idx_q;
        gap_d     = gap_q;
        if (issue_s) begin
            gap_d = GAP_LOAD;
            if (issue_idx_s == LAST_IDX) begin
                pix_idx_d = issue_idx_s;
            end else begin
                pix_idx_d = issue_idx_s + ADDR_ONE;
            end
        end else if (launch_s) begin
            gap_d     = GAP_ZERO;
            pix_idx_d = ADDR_ZERO;
        end else begin
            pix_idx_d = pix_idx_q;
            // The gap counter keeps running during hold so a hold never
            // stretches or shortens the programmed spacing.
            if (gap_q != GAP_ZERO) begin
                gap_d = gap_q - GAP_ONE;
            end else begin
                gap_d = gap_q;
            end
        end
    end

    // Pixel index and gap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_idx_q <= ADDR_ZERO;
            gap_q     <= GAP_ZERO;
        end else begin
            pix_idx_q <= pix_idx_d;
            gap_q     <= gap_d;
        end
    end

    // Read port and pixel pipeline: rd at t, data valid at t+1, strobe at t+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= ADDR_ZERO;
            mem_rd_q   <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            gray_q     <= 8'd0;
        end else begin
            mem_rd_q <= issue_s;
            if (issue_s) begin
                mem_addr_q <= issue_idx_s;
            end else begin
                mem_addr_q <= mem_addr_q;
            end
            vld_q  <= mem_rd_q;
            done_q <= vld_q;
            if (vld_q) begin
                gray_q <= mem_data_i;
            end else begin
                gray_q <= gray_q;
            end
        end
    end

    // Frame sequencing FSM with registered busy and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch_s) begin
                        busy_q <= 1'b1;
                        if (last_issue_s) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b1;
                    if (last_issue_s) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    busy_q <= 1'b1;
                    if (drain_done_s) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    // start_i is deliberately not looked at here.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_rd_o     = mem_rd_q;
    assign grayscale_o  = gray_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: doc/grayscale_frame_streamer.md
# grayscale_frame_streamer

Transmit end of the grayscale pixel stream consumed by the Sobel data buffer. On a start command it reads one frame of 8-bit grayscale pixels from a synchronous frame RAM in raster order and presents each pixel on `grayscale_o` with a one-cycle `done_o` strobe, the same pixel/strobe pair the Sobel buffer samples. A programmable inter-pixel gap sets the pixel rate, and a hold input pauses the stream. Sits between the frame memory and the Sobel pipeline input.

## Interface
- `IMG_WIDTH`, 640, pixels per line.
- `IMG_HEIGHT`, 480, lines per frame.
- `ADDR_WIDTH`, 19, frame RAM address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.
- `GAP`, 0, idle cycles between consecutive pixel issues; 0 gives one pixel per cycle.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  begin a frame; sampled only in IDLE.
- `hold_i`  in  1  when high, no new RAM read is issued; reads already in flight still complete.
- `mem_addr_o`  out  ADDR_WIDTH  frame RAM read address, registered.
- `mem_rd_o`  out  1  read enable, registered; high for exactly one cycle per pixel.
- `mem_data_i`  in  8  RAM read data; valid the cycle after `mem_rd_o` is high.
- `grayscale_o`  out  8  pixel value, registered; holds its last value between strobes.
- `done_o`  out  1  one-cycle strobe marking `grayscale_o` as a new valid pixel.
- `busy_o`  out  1  high while a frame is in progress.
- `frame_done_o`  out  1  one-cycle pulse at end of frame.

## Operation
- State machine with four states:
  - IDLE: if `start_i` is high, clear the address counter, load the gap counter with 0, and go to RUN.
  - RUN: issue a read when `hold_i`=0 and the gap counter is 0. Issuing means `mem_addr_o`=pixel index, `mem_rd_o`=1, and the gap counter reloads to GAP. When the issued index is N-1 (N = IMG_WIDTH*IMG_HEIGHT), go to DRAIN.
  - DRAIN: wait until the last pixel's `done_o` has been emitted, then go to DONE.
  - DONE: assert `frame_done_o` for one cycle, then go to IDLE.
- The gap counter decrements once per cycle toward 0, independent of `hold_i`.
- A hold never extends a gap already elapsed and never shortens one.
- Pixel pipeline is a one-bit valid shift register aligned with RAM latency:
  - `mem_rd_o` at cycle t gives valid data at t+1.
  - At the edge ending t+1, `grayscale_o`<=`mem_data_i` and `done_o`=1 during t+2.
- Address is a linear counter 0..N-1, which is raster order (row*IMG_WIDTH+col). No wrap; the counter stops at N-1.
- `busy_o` is high in RUN, DRAIN and DONE.
- `start_i` outside IDLE is ignored, including in the DONE cycle.
- A start pulse held high across IDLE re-entry starts a new frame immediately.

## Timing
- Reset values: `mem_addr_o`=0, `mem_rd_o`=0, `grayscale_o`=0, `done_o`=0, `busy_o`=0, `frame_done_o`=0; state IDLE; valid pipe cleared.
- `start_i` sampled at edge E: first `mem_rd_o` in the cycle after E (with `hold_i`=0); first `done_o` two cycles later.
- Steady state with `hold_i`=0: `done_o` strobes exactly GAP+1 cycles apart.
- `frame_done_o` is asserted in the cycle immediately after the last `done_o`. `busy_o` falls the cycle after that.
- Frame length with `hold_i`=0 is N*(GAP+1)-GAP+3 cycles of `busy_o`, counted from the first `mem_rd_o` through the `frame_done_o` cycle.
- `hold_i` raised in the same cycle a read would issue blocks that read. A read already issued still produces its `done_o` on schedule.
- Reset mid-frame: everything returns to reset values asynchronously. In-flight data is discarded and no `done_o` or `frame_done_o` follows.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=3, GAP=0, RAM[i]=i+16, pulse `start_i` -> 12 consecutive `done_o` with `grayscale_o`=16..27, first `done_o` 2 cycles after first `mem_rd_o`, `frame_done_o` the cycle after the 12th strobe.
- Same image, GAP=2 -> strobes exactly 3 cycles apart, values 16..27, `busy_o` high for 12*3-2+3=37 cycles.
- GAP=0, `hold_i` high for 5 cycles after pixel 4 is issued -> pixel 4 still strobed on schedule, then a 5-cycle strobe gap, pixels 5..11 resume in order with none lost or duplicated.
- `start_i` pulsed again during RUN and in the DONE cycle -> ignored; exactly 12 strobes and one `frame_done_o`.
- `rst` asserted after pixel 6 issued -> all outputs 0 at once, no further `done_o` or `frame_done_o`; a new start then streams a full frame from address 0.
- IMG_WIDTH=1, IMG_HEIGHT=1 -> exactly one `done_o` with RAM[0], then `frame_done_o`, then IDLE.
